// File: rtl/ece429_srec_loader_pkg.sv
// rtl/ece429_srec_loader_pkg.sv - shared states, ASCII constants and record-type table for the S-record loader
package ece429_srec_loader_pkg;

  typedef enum logic [3:0] {
    ST_SYNC,
    ST_TYPE,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_EOL,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    REC_HDR,
    REC_DATA,
    REC_TERM
  } rec_kind_e;

  typedef struct packed {
    logic      valid;
    rec_kind_e kind;
    logic [2:0] alen;
  } rec_info_t;

  localparam logic [1:0] ACCESS_WORD = 2'b00;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Record type character -> kind and address-field length in bytes
  function automatic rec_info_t rec_decode(input logic [7:0] c);
    rec_info_t r;
    r = '0;
    case (c)
      8'h30, 8'h35: r = '{valid: 1'b1, kind: REC_HDR,  alen: 3'd2};
      8'h31:        r = '{valid: 1'b1, kind: REC_DATA, alen: 3'd2};
      8'h32:        r = '{valid: 1'b1, kind: REC_DATA, alen: 3'd3};
      8'h33:        r = '{valid: 1'b1, kind: REC_DATA, alen: 3'd4};
      8'h37:        r = '{valid: 1'b1, kind: REC_TERM, alen: 3'd4};
      8'h38:        r = '{valid: 1'b1, kind: REC_TERM, alen: 3'd3};
      8'h39:        r = '{valid: 1'b1, kind: REC_TERM, alen: 3'd2};
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ece429_hex_nibble.sv
// rtl/ece429_hex_nibble.sv - combinational ASCII hex digit to nibble decoder
module ece429_hex_nibble (
  input  logic [7:0] ascii_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  // Accept 0-9, A-F, a-f; everything else flags invalid
  always_comb begin
    valid_o  = 1'b1;
    nibble_o = 4'd0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      nibble_o = ascii_i[3:0];
    end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                 (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
      nibble_o = ascii_i[3:0] + 4'd9;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/ece429_srec_loader.sv
// rtl/ece429_srec_loader.sv - S-record byte stream to CPU memory-load port; SREC_CHECKSUM_EN enables checksum checking
module ece429_srec_loader
  import ece429_srec_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_OFFSET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        stall,
  output logic [31:0] parse_addr,
  output logic [31:0] parse_data,
  output logic [1:0]  parse_access_size,
  output logic [31:0] max_fetch_addr,
  output logic [31:0] entry_addr,
  output logic        load_done,
  output logic        load_error
);

  state_e     state_q, state_d;
  logic       nib_q;
  logic [3:0] hi_q;
  rec_kind_e  kind_q;
  logic [2:0] alen_q;
  logic [7:0] cnt_q;
  logic [7:0] dlen_q;
  logic [1:0] idx_q;
  logic [23:0] buf_q;
  logic [31:0] addr_q;
  logic [31:0] parse_addr_q;
  logic [31:0] parse_data_q;
  logic [31:0] max_q;
  logic [31:0] entry_q;
  logic        done_q;
  logic        err_q;
  logic        stall_q;

  logic        accept;
  logic        hex_valid;
  logic [3:0]  hex_nib;
  logic [7:0]  byte_val;
  logic        in_field;
  logic        byte_done;
  logic        last_byte;
  logic        is_eol;
  logic [7:0]  dlen_calc;
  logic        bad_len;
  logic        sum_ok;
  logic        word_wr;
  logic [31:0] wr_addr;
  rec_info_t   rec_info;

  ece429_hex_nibble u_hex (
    .ascii_i  (rx_data),
    .valid_o  (hex_valid),
    .nibble_o (hex_nib)
  );

  assign accept    = rx_valid && rx_ready;
  assign byte_val  = {hi_q, hex_nib};
  assign in_field  = (state_q == ST_COUNT) || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA)  || (state_q == ST_CSUM);
  assign byte_done = accept && in_field && hex_valid && nib_q;
  assign last_byte = (cnt_q == 8'd1);
  assign is_eol    = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign rec_info  = rec_decode(rx_data);
  assign dlen_calc = byte_val - {5'b0, alen_q} - 8'd1;
  assign bad_len   = (byte_val < ({5'b0, alen_q} + 8'd1)) ||
                     ((kind_q == REC_DATA) && (dlen_calc[1:0] != 2'b00));
  assign word_wr   = byte_done && (state_q == ST_DATA) && (kind_q == REC_DATA) && (idx_q == 2'd3);
  assign wr_addr   = addr_q - ADDR_OFFSET;

`ifdef SREC_CHECKSUM_EN
  logic [7:0] sum_q;

  assign sum_ok = ((sum_q + byte_val) == 8'hFF);

  // Running sum of count, address and data bytes, cleared at each record type
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 8'd0;
    end else if (accept && state_q == ST_TYPE) begin
      sum_q <= 8'd0;
    end else if (byte_done && state_q != ST_CSUM) begin
      sum_q <= sum_q + byte_val;
    end
  end
`else
  assign sum_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one transition per accepted character, hex fields advance per full byte
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        ST_SYNC: begin
          if (rx_data == ASCII_S)  state_d = ST_TYPE;
          else if (!is_eol)        state_d = ST_ERR;
        end
        ST_TYPE: begin
          state_d = rec_info.valid ? ST_COUNT : ST_ERR;
        end
        ST_COUNT, ST_ADDR, ST_DATA, ST_CSUM: begin
          if (!hex_valid) begin
            state_d = ST_ERR;
          end else if (nib_q) begin
            case (state_q)
              ST_COUNT: state_d = bad_len ? ST_ERR : ST_ADDR;
              ST_ADDR: begin
                if (last_byte) state_d = (dlen_q == 8'd0) ? ST_CSUM : ST_DATA;
              end
              ST_DATA: begin
                if (last_byte) state_d = ST_CSUM;
              end
              default: begin
                if (!sum_ok)                 state_d = ST_ERR;
                else if (kind_q == REC_TERM) state_d = ST_DONE;
                else                         state_d = ST_EOL;
              end
            endcase
          end
        end
        ST_EOL: begin
          if (is_eol)                  state_d = ST_SYNC;
          else if (rx_data == ASCII_S) state_d = ST_TYPE;
          else                         state_d = ST_ERR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from state: the byte source is refused once loading has ended
  always_comb begin
    rx_ready = (state_q != ST_DONE) && (state_q != ST_ERR);
  end

  // Field datapath: nibble pairing, counters, address, word assembly and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nib_q        <= 1'b0;
      hi_q         <= 4'd0;
      kind_q       <= REC_HDR;
      alen_q       <= 3'd0;
      cnt_q        <= 8'd0;
      dlen_q       <= 8'd0;
      idx_q        <= 2'd0;
      buf_q        <= 24'd0;
      addr_q       <= 32'd0;
      parse_addr_q <= 32'd0;
      parse_data_q <= 32'd0;
      max_q        <= 32'd0;
      entry_q      <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      stall_q      <= 1'b1;
    end else begin
      if (accept && in_field && hex_valid) begin
        nib_q <= ~nib_q;
        if (!nib_q) hi_q <= hex_nib;
      end
      if (accept && state_q == ST_TYPE) begin
        kind_q <= rec_info.kind;
        alen_q <= rec_info.alen;
      end
      if (byte_done) begin
        case (state_q)
          ST_COUNT: begin
            cnt_q  <= {5'b0, alen_q};
            dlen_q <= dlen_calc;
            addr_q <= 32'd0;
          end
          ST_ADDR: begin
            addr_q <= {addr_q[23:0], byte_val};
            cnt_q  <= last_byte ? dlen_q : cnt_q - 8'd1;
            idx_q  <= 2'd0;
          end
          ST_DATA: begin
            buf_q <= {buf_q[15:0], byte_val};
            idx_q <= idx_q + 2'd1;
            cnt_q <= cnt_q - 8'd1;
            if (word_wr) begin
              parse_data_q <= {buf_q, byte_val};
              parse_addr_q <= wr_addr;
              addr_q       <= addr_q + 32'd4;
              if (wr_addr > max_q) max_q <= wr_addr;
            end
          end
          ST_CSUM: begin
            if (sum_ok && kind_q == REC_TERM) begin
              entry_q <= addr_q;
              done_q  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
      if (state_d == ST_ERR) err_q <= 1'b1;
      stall_q <= (state_q != ST_DONE);
    end
  end

  assign stall             = stall_q;
  assign parse_addr        = parse_addr_q;
  assign parse_data        = parse_data_q;
  assign parse_access_size = ACCESS_WORD;
  assign max_fetch_addr    = max_q;
  assign entry_addr        = entry_q;
  assign load_done         = done_q;
  assign load_error        = err_q;

endmodule

// File: tb/tb_ece429_srec_loader.sv
// tb/tb_ece429_srec_loader.sv - directed scoreboard bench for the S-record loader (zero and non-zero ADDR_OFFSET)
module tb_ece429_srec_loader;

  localparam logic [31:0] OFF1 = 32'h8002_0000;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        rdy0, stl0, dn0, er0, rdy1, stl1, dn1, er1;
  logic [31:0] pa0, pd0, mx0, en0, pa1, pd1, mx1, en1;
  logic [1:0]  ps0, ps1;

  ece429_srec_loader #(.ADDR_OFFSET(32'h0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .stall(stl0), .parse_addr(pa0), .parse_data(pd0),
    .parse_access_size(ps0), .max_fetch_addr(mx0), .entry_addr(en0),
    .load_done(dn0), .load_error(er0)
  );

  ece429_srec_loader #(.ADDR_OFFSET(OFF1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .stall(stl1), .parse_addr(pa1), .parse_data(pd1),
    .parse_access_size(ps1), .max_fetch_addr(mx1), .entry_addr(en1),
    .load_done(dn1), .load_error(er1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wexp_t;

  wexp_t       sb[$];
  logic [7:0]  dq[$];
  int          checks = 0;
  int          errors = 0;
  bit          lower = 0;
  bit          gap = 0;
  bit          cr_only = 0;
  logic [31:0] mdl_mx0 = 0;
  logic [31:0] mdl_mx1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // exp = {load_done, load_error, stall, rx_ready}
  task automatic chk_status(input string tag, input logic [3:0] exp);
    chk({tag, "/d0"}, {28'd0, dn0, er0, stl0, rdy0}, {28'd0, exp});
    chk({tag, "/d1"}, {28'd0, dn1, er1, stl1, rdy1}, {28'd0, exp});
  endtask

  task automatic chk_reset(input string tag);
    chk_status(tag, 4'b0011);
    chk({tag, "/pa0"}, pa0, 32'd0);
    chk({tag, "/pd0"}, pd0, 32'd0);
    chk({tag, "/mx0"}, mx0, 32'd0);
    chk({tag, "/en0"}, en0, 32'd0);
    chk({tag, "/ps0"}, {30'd0, ps0}, 32'd0);
    chk({tag, "/pa1"}, pa1, 32'd0);
    chk({tag, "/mx1"}, mx1, 32'd0);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    return (lower ? 8'h61 : 8'h41) + {4'd0, n} - 8'd10;
  endfunction

  task automatic send_char(input logic [7:0] c);
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clock); #1;
    end
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_hex(input logic [7:0] b);
    send_char(hexc(b[7:4]));
    send_char(hexc(b[3:0]));
  endtask

  task automatic send_eol();
    send_char(8'h0D);
    if (!cr_only) send_char(8'h0A);
  endtask

  // Pop the oldest expected word and compare both instances plus the max model
  task automatic chk_word();
    wexp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow observed=%0d expected=1", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.a > mdl_mx0) mdl_mx0 = e.a;
      if ((e.a - OFF1) > mdl_mx1) mdl_mx1 = e.a - OFF1;
      chk("word_addr0", pa0, e.a);
      chk("word_data0", pd0, e.d);
      chk("word_addr1", pa1, e.a - OFF1);
      chk("word_data1", pd1, e.d);
      chk("max0", mx0, mdl_mx0);
      chk("max1", mx1, mdl_mx1);
    end
  endtask

  task automatic send_rec(input logic [7:0] t, input logic [31:0] a, input int alen,
                          input logic [7:0] cdelta);
    logic [7:0] sum, b, cnt;
    bit is_data;
    wexp_t e;
    is_data = (t == "1") || (t == "2") || (t == "3");
    cnt = 8'(alen + dq.size() + 1);
    sum = cnt;
    if (is_data) begin
      for (int w = 0; w < dq.size() / 4; w++) begin
        e.a = a + 32'(4 * w);
        e.d = {dq[4*w], dq[4*w+1], dq[4*w+2], dq[4*w+3]};
        sb.push_back(e);
      end
    end
    send_char("S");
    send_char(t);
    send_hex(cnt);
    for (int i = alen - 1; i >= 0; i--) begin
      b = a[8*i +: 8];
      sum += b;
      send_hex(b);
    end
    for (int i = 0; i < dq.size(); i++) begin
      sum += dq[i];
      send_hex(dq[i]);
      if (is_data && (i % 4) == 3) chk_word();
    end
    send_hex(~sum + cdelta);
  endtask

  // Called right after the termination record's last checksum character
  task automatic chk_term(input logic [31:0] entry);
    chk_status("term_edge", 4'b1010);
    @(posedge clock); #1;
    chk_status("term_stall", 4'b1000);
    chk("entry0", en0, entry);
    chk("entry1", en1, entry);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clock); #1;
    reset_n  = 1'b1;
    sb.delete();
    mdl_mx0 = 0;
    mdl_mx1 = 0;
    @(posedge clock); #1;
  endtask

  task automatic file1();
    dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_rec("3", 32'h0, 4, 8'h00);
    send_eol();
    dq.delete();
    send_rec("7", 32'h0, 4, 8'h00);
    chk_term(32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk_reset("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: single word then S7
    file1();

    // 2: two words at 80020000, S1 with no data first
    do_reset();
    dq.delete();
    send_rec("1", 32'h0, 2, 8'h00);
    send_eol();
    chk("s1_nodata_addr", pa0, 32'h0);
    dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_rec("3", 32'h8002_0000, 4, 8'h00);
    send_eol();
    chk("max1_final", mx1, 32'h4);
    dq.delete();
    send_rec("7", 32'h8002_0000, 4, 8'h00);
    chk_term(32'h8002_0000);

    // 3: same record, checksum off by one
    do_reset();
    dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_rec("3", 32'h8002_0000, 4, 8'h01);
`ifdef SREC_CHECKSUM_EN
    chk_status("bad_csum", 4'b0110);
    @(posedge clock); #1;
    chk_status("bad_csum_hold", 4'b0110);
`else
    chk_status("csum_ignored", 4'b0011);
    send_eol();
    dq.delete();
    send_rec("7", 32'h8002_0000, 4, 8'h00);
    chk_term(32'h8002_0000);
`endif

    // 4: lower-case, idle cycle between bytes, CR-only line ends
    do_reset();
    lower = 1; gap = 1; cr_only = 1;
    file1();
    lower = 0; gap = 0; cr_only = 0;

    // 5a: illegal character in data field
    do_reset();
    send_char("S"); send_char("3"); send_hex(8'h09);
    for (int i = 0; i < 4; i++) send_hex(8'h00);
    send_char("1"); send_char("G");
    chk_status("bad_hex", 4'b0110);

    // 5b: S3 with three data bytes
    do_reset();
    send_char("S"); send_char("3"); send_hex(8'h08);
    chk_status("bad_len", 4'b0110);

    // 6: reset mid-record after an earlier word, then a clean file
    do_reset();
    dq = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_rec("3", 32'h10, 4, 8'h00);
    send_eol();
    send_char("S"); send_char("3"); send_hex(8'h09);
    for (int i = 0; i < 4; i++) send_hex(8'h00);
    send_hex(8'hDE); send_hex(8'hAD);
    reset_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    sb.delete();
    mdl_mx0 = 0;
    mdl_mx1 = 0;
    @(posedge clock); #1;
    file1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
